// File: rtl/cr_fifo_sched_pkg.sv
// Shared types and width helpers for the round-robin FIFO read scheduler
// and its rotate-priority picker.
package cr_fifo_sched_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } sched_state_e;

   // Width of an index into n sources; never narrower than one bit.
   function automatic int src_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a counter that must hold the value n itself.
   function automatic int log_vec(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/cr_rr_pick.sv
// Combinational rotate-priority picker: grants the first requester at or
// after ptr, wrapping modulo N_SRC.
module cr_rr_pick
   import cr_fifo_sched_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int SW    = src_idx_w(N_SRC)
) (
   input  logic [N_SRC-1:0] req,
   input  logic [SW-1:0]    ptr,
   output logic [SW-1:0]    gnt_idx,
   output logic             any_gnt
);

   int idx;

   // Scan from the farthest offset down so the nearest requester wins.
   always_comb begin
      gnt_idx = '0;
      any_gnt = 1'b0;
      idx     = 0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N_SRC;
         if (req[idx]) begin
            gnt_idx = SW'(idx);
            any_gnt = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cr_fifo_rr_sched.sv
// Round-robin read scheduler: drains N_SRC show-ahead FIFOs in bounded bursts
// onto one registered valid/ready output stream.
module cr_fifo_rr_sched
   import cr_fifo_sched_pkg::*;
#(
   parameter  int N_DATA_BITS = 64,
   parameter  int N_SRC       = 4,
   parameter  int MAX_BURST   = 4,
   localparam int SW          = src_idx_w(N_SRC),
   localparam int BW          = log_vec(MAX_BURST)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [N_SRC-1:0]             src_empty,
   input  logic [N_SRC*N_DATA_BITS-1:0] src_rdata,
   output logic [N_SRC-1:0]             src_ren,
   input  logic                         cfg_enable,
   input  logic [N_SRC-1:0]             cfg_mask,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [N_DATA_BITS-1:0]       out_data,
   output logic [SW-1:0]                out_src,
   output logic                         out_eob,
   output logic                         busy
);

   // Output handshake: a word transfers on a rising clk edge where
   // out_valid & out_ready; out_valid and the word stay stable until then.

   sched_state_e           state_q, state_d;
   logic [SW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [BW-1:0]          burst_cnt_q, burst_cnt_d;
   logic [N_SRC-1:0]       elig;
   logic                   slot_ok, hold_burst, any_gnt, pop, eob_d;
   logic [SW-1:0]          pick_ptr, gnt_idx, grant;
   logic [N_DATA_BITS-1:0] sel_data;

   function automatic logic [SW-1:0] ptr_inc(input logic [SW-1:0] p);
      return (int'(p) == N_SRC - 1) ? '0 : p + SW'(1);
   endfunction

   assign elig       = {N_SRC{cfg_enable}} & cfg_mask & ~src_empty;
   assign slot_ok    = ~out_valid | out_ready;
   assign hold_burst = (state_q == BURST) & elig[rr_ptr_q];

   // A burst whose source drops out hands over in the same cycle, searching
   // from the next source, so a draining FIFO costs no bubble on the output.
   assign pick_ptr = (state_q == BURST) ? ptr_inc(rr_ptr_q) : rr_ptr_q;

   cr_rr_pick #(
      .N_SRC (N_SRC),
      .SW    (SW)
   ) u_pick (
      .req     (elig),
      .ptr     (pick_ptr),
      .gnt_idx (gnt_idx),
      .any_gnt (any_gnt)
   );

   assign grant    = hold_burst ? rr_ptr_q : gnt_idx;
   // rst_n keeps the pop strobes quiet while the scheduler is held in reset.
   assign pop      = rst_n & slot_ok & (hold_burst | any_gnt);
   assign sel_data = src_rdata[int'(grant)*N_DATA_BITS +: N_DATA_BITS];
   assign busy     = (state_q == BURST) | out_valid;

   always_comb begin
      src_ren        = '0;
      src_ren[grant] = pop;
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      eob_d       = 1'b0;
      if (hold_burst) begin
         if (slot_ok) begin
            burst_cnt_d = burst_cnt_q + BW'(1);
            if (int'(burst_cnt_q) + 1 >= MAX_BURST) begin
               eob_d    = 1'b1;
               rr_ptr_d = ptr_inc(rr_ptr_q);
               state_d  = IDLE;
            end
         end
      end else begin
         if (state_q == BURST) begin
            state_d  = IDLE;
            rr_ptr_d = ptr_inc(rr_ptr_q);
         end
         if (pop) begin
            burst_cnt_d = BW'(1);
            if (MAX_BURST > 1) begin
               state_d  = BURST;
               rr_ptr_d = gnt_idx;
            end else begin
               eob_d    = 1'b1;
               state_d  = IDLE;
               rr_ptr_d = ptr_inc(gnt_idx);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_src     <= '0;
         out_eob     <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         if (pop) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= grant;
            out_eob   <= eob_d;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   a_ren_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(src_ren));
   a_ren_not_empty: assert property (@(posedge clk) disable iff (!rst_n)
      (src_ren & src_empty) == '0);

endmodule

// File: tb/tb_cr_fifo_rr_sched.sv
// Bench for cr_fifo_rr_sched: a 4-source/burst-4 instance and a
// 3-source/burst-1 instance fed by queue-backed show-ahead FIFO models.
module tb_cr_fifo_rr_sched;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT A: N_SRC=4, MAX_BURST=4 ----------------
   logic [3:0]   src_empty_a = '1;
   logic [255:0] src_rdata_a = '0;
   logic [3:0]   src_ren_a;
   logic         cfg_enable_a = 1'b0;
   logic [3:0]   cfg_mask_a = 4'b1111;
   logic         out_valid_a, out_eob_a, busy_a;
   logic         out_ready_a = 1'b1;
   logic [63:0]  out_data_a;
   logic [1:0]   out_src_a;

   cr_fifo_rr_sched #(.N_DATA_BITS(64), .N_SRC(4), .MAX_BURST(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .src_empty(src_empty_a), .src_rdata(src_rdata_a),
      .src_ren(src_ren_a), .cfg_enable(cfg_enable_a), .cfg_mask(cfg_mask_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
      .out_src(out_src_a), .out_eob(out_eob_a), .busy(busy_a));

   // ---------------- DUT B: N_SRC=3, MAX_BURST=1 ----------------
   logic [2:0]   src_empty_b = '1;
   logic [191:0] src_rdata_b = '0;
   logic [2:0]   src_ren_b;
   logic         cfg_enable_b = 1'b0;
   logic [2:0]   cfg_mask_b = 3'b111;
   logic         out_valid_b, out_eob_b, busy_b;
   logic         out_ready_b = 1'b1;
   logic [63:0]  out_data_b;
   logic [1:0]   out_src_b;

   cr_fifo_rr_sched #(.N_DATA_BITS(64), .N_SRC(3), .MAX_BURST(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .src_empty(src_empty_b), .src_rdata(src_rdata_b),
      .src_ren(src_ren_b), .cfg_enable(cfg_enable_b), .cfg_mask(cfg_mask_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
      .out_src(out_src_b), .out_eob(out_eob_b), .busy(busy_b));

   // ---------------- bench state ----------------
   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] fq [8][$];        // FIFO contents seen by the DUTs (A: 0..3, B: 4..6)
   logic [63:0] mq [8][$];        // model's own copy of what each source still holds
   logic [68:0] exp_q [2][$];     // expected {src[3:0], eob, data[63:0]}
   int          mptr [2];
   logic [3:0]  mmask_a = 4'b1111;
   bit          chk_en [2];
   bit          hold_v [2];
   logic [68:0] hold_w [2];
   int          run_cur = 0;
   int          run_max = 0;
   int          ser = 0;
   logic [3:0]  rdy_pat = 4'b1001;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic load(input int w, input int i, input int n);
      logic [63:0] d;
      for (int j = 0; j < n; j++) begin
         d = {8'hA0 + 8'(w), 8'(i), 16'h0, 32'(ser)};
         ser++;
         fq[w*4+i].push_back(d);
         mq[w*4+i].push_back(d);
      end
   endtask

   // Expected order: the first eligible source at or after the pointer gives
   // up to MAX_BURST words; eob marks the word that fills the burst.
   task automatic model_run(input int w);
      int n, mb, g, k, s;
      logic [3:0] msk;
      n   = (w != 0) ? 3 : 4;
      mb  = (w != 0) ? 1 : 4;
      msk = (w != 0) ? 4'b0111 : mmask_a;
      for (int guard = 0; guard < 64; guard++) begin
         g = -1;
         for (int o = 0; o < n; o++) begin
            s = (mptr[w] + o) % n;
            if (g < 0 && msk[s] && mq[w*4+s].size() > 0) g = s;
         end
         if (g < 0) break;
         k = (mq[w*4+g].size() < mb) ? mq[w*4+g].size() : mb;
         for (int j = 0; j < k; j++)
            exp_q[w].push_back({4'(g), 1'(j == mb - 1), mq[w*4+g].pop_front()});
         mptr[w] = (g + 1) % n;
      end
   endtask

   task automatic wait_drain(input int w, input int budget, input bit use_pat);
      bit done;
      done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         if (exp_q[w].size() == 0 && !((w != 0) ? out_valid_b : out_valid_a)) done = 1'b1;
         else begin
            if (use_pat) out_ready_a = rdy_pat[c % 4];
            step(1);
         end
      end
      out_ready_a = 1'b1;
      n_cmp++;
      if (!done) begin
         n_bad++;
         $display("FAIL drain_dut%0d: %0d words outstanding, required 0", w, exp_q[w].size());
      end
   endtask

   // ---------------- FIFO models (show-ahead, pop on src_ren) ----------------
   task automatic fifo_pop(input int k);
      n_cmp++;
      if (fq[k].size() == 0) begin
         n_bad++;
         $display("FAIL pop_empty fifo%0d: got pop, required no pop", k);
      end else void'(fq[k].pop_front());
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) if (src_ren_a[i]) fifo_pop(i);
      for (int i = 0; i < 3; i++) if (src_ren_b[i]) fifo_pop(4 + i);
      #1;
      for (int i = 0; i < 4; i++) begin
         src_empty_a[i] = (fq[i].size() == 0);
         src_rdata_a[i*64 +: 64] = (fq[i].size() == 0) ? 64'h0 : fq[i][0];
      end
      for (int i = 0; i < 3; i++) begin
         src_empty_b[i] = (fq[4+i].size() == 0);
         src_rdata_b[i*64 +: 64] = (fq[4+i].size() == 0) ? 64'h0 : fq[4+i][0];
      end
   end

   // ---------------- scoreboard / compare process ----------------
   task automatic chk_word(input int w, input logic v, input logic r, input logic [68:0] act);
      logic [68:0] e;
      if (!chk_en[w]) return;
      if (hold_v[w]) begin
         n_cmp++;
         if (!v || act !== hold_w[w]) begin
            n_bad++;
            $display("FAIL stall_hold_dut%0d: got v=%0b %h, required v=1 %h", w, v, act, hold_w[w]);
         end
      end
      hold_v[w] = v && !r;
      hold_w[w] = act;
      if (v && r) begin
         n_cmp++;
         if (exp_q[w].size() == 0) begin
            n_bad++;
            $display("FAIL word_dut%0d: got %h, required no word", w, act);
         end else begin
            e = exp_q[w].pop_front();
            if (act !== e) begin
               n_bad++;
               $display("FAIL word_dut%0d: got %h, required %h", w, act, e);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk_word(0, out_valid_a, out_ready_a, {2'b00, out_src_a, out_eob_a, out_data_a});
         chk_word(1, out_valid_b, out_ready_b, {2'b00, out_src_b, out_eob_b, out_data_b});
         if (src_ren_a != 4'b0) begin
            n_cmp++;
            if (!$onehot(src_ren_a) || (src_ren_a & src_empty_a) != 4'b0) begin
               n_bad++;
               $display("FAIL ren_a: got ren=%b empty=%b, required onehot pop of non-empty", src_ren_a, src_empty_a);
            end
         end
         if (src_ren_b != 3'b0) begin
            n_cmp++;
            if (!$onehot(src_ren_b) || (src_ren_b & src_empty_b) != 3'b0) begin
               n_bad++;
               $display("FAIL ren_b: got ren=%b empty=%b, required onehot pop of non-empty", src_ren_b, src_empty_b);
            end
         end
         if (out_valid_a) begin
            n_cmp++;
            if (!busy_a) begin
               n_bad++;
               $display("FAIL busy_a: got 0, required 1 while out_valid");
            end
         end
      end
      if (out_valid_a) begin
         run_cur++;
         if (run_cur > run_max) run_max = run_cur;
      end else run_cur = 0;
   end

   // ---------------- directed stimulus ----------------
   int src_lit [6] = '{0, 1, 2, 0, 1, 2};
   logic [63:0] d0;

   initial begin
      chk_en[0] = 1'b1; chk_en[1] = 1'b1;
      hold_v[0] = 1'b0; hold_v[1] = 1'b0;
      mptr[0] = 0; mptr[1] = 0;
      step(3);
      chk("rst_out_valid", 64'(out_valid_a), 64'd0);
      chk("rst_out_data", out_data_a, 64'd0);
      chk("rst_out_src", 64'(out_src_a), 64'd0);
      chk("rst_out_eob", 64'(out_eob_a), 64'd0);
      chk("rst_busy", 64'(busy_a), 64'd0);
      chk("rst_src_ren", 64'(src_ren_a), 64'd0);
      rst_n = 1'b1;
      step(1);

      // 1: all four sources hold 8 words, bursts of 4, no backpressure
      d0 = {8'hA0, 8'd0, 16'h0, 32'(ser)};
      load(0, 0, 8); load(0, 1, 8); load(0, 2, 8); load(0, 3, 8);
      model_run(0);
      chk("model_eob_w3", 64'(exp_q[0][3][64]), 64'd1);
      chk("model_eob_w2", 64'(exp_q[0][2][64]), 64'd0);
      chk("model_src_w4", 64'(exp_q[0][4][68:65]), 64'd1);
      step(1);
      run_max = 0;
      cfg_enable_a = 1'b1;
      #1;
      chk("first_pop_ren", 64'(src_ren_a), 64'b0001);
      chk("first_pop_valid", 64'(out_valid_a), 64'd0);
      step(1);
      chk("latency_valid", 64'(out_valid_a), 64'd1);
      chk("latency_src", 64'(out_src_a), 64'd0);
      chk("latency_data", out_data_a, d0);
      wait_drain(0, 200, 1'b0);
      chk("t1_run_len", 64'(run_max), 64'd32);

      // 2: src1 holds only 2 words
      run_max = 0;
      load(0, 0, 8); load(0, 1, 2); load(0, 2, 8); load(0, 3, 8);
      model_run(0);
      chk("model_t2_w5", 64'(exp_q[0][5][68:64]), {59'd0, 4'd1, 1'b0});
      chk("model_t2_w6", 64'(exp_q[0][6][68:65]), 64'd2);
      wait_drain(0, 200, 1'b0);
      chk("t2_run_len", 64'(run_max), 64'd26);

      // 3: backpressure pattern 1,0,0,1 on out_ready
      load(0, 0, 8); load(0, 1, 8);
      model_run(0);
      wait_drain(0, 300, 1'b1);

      // 4: mask 0101 serves only src0/src2, then unmask the rest
      cfg_mask_a = 4'b0101; mmask_a = 4'b0101;
      load(0, 0, 8); load(0, 1, 8); load(0, 2, 8); load(0, 3, 8);
      model_run(0);
      chk("model_t4_w0", 64'(exp_q[0][0][68:65]), 64'd2);
      chk("model_t4_w4", 64'(exp_q[0][4][68:65]), 64'd0);
      wait_drain(0, 200, 1'b0);
      cfg_mask_a = 4'b1111; mmask_a = 4'b1111;
      model_run(0);
      wait_drain(0, 200, 1'b0);

      // enable cleared mid-burst: no pop next cycle, registered word drains
      cfg_enable_a = 1'b0;
      load(0, 0, 8);
      exp_q[0].push_back({4'd0, 1'b0, mq[0].pop_front()});
      exp_q[0].push_back({4'd0, 1'b0, mq[0].pop_front()});
      mptr[0] = 1;
      step(1);
      cfg_enable_a = 1'b1;
      step(2);
      cfg_enable_a = 1'b0;
      #1;
      chk("dis_ren", 64'(src_ren_a), 64'd0);
      chk("dis_valid_held", 64'(out_valid_a), 64'd1);
      step(1);
      chk("dis_drained", 64'(out_valid_a), 64'd0);
      chk("dis_ren_next", 64'(src_ren_a), 64'd0);
      chk("dis_busy", 64'(busy_a), 64'd0);
      cfg_enable_a = 1'b1;
      model_run(0);
      wait_drain(0, 200, 1'b0);

      // 5: N_SRC=3, MAX_BURST=1 strict rotation with wrap 2 -> 0
      load(1, 0, 2); load(1, 1, 2); load(1, 2, 2);
      model_run(1);
      for (int i = 0; i < 6; i++)
         chk("model_b_order", 64'(exp_q[1][i][68:64]), {59'd0, 4'(src_lit[i]), 1'b1});
      cfg_enable_b = 1'b1;
      wait_drain(1, 100, 1'b0);

      // 6: one-cycle reset mid-burst
      chk_en[0] = 1'b0;
      load(0, 0, 8); load(0, 1, 8);
      step(3);
      chk("pre_rst_busy", 64'(busy_a), 64'd1);
      chk("pre_rst_valid", 64'(out_valid_a), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 64'(out_valid_a), 64'd0);
      chk("rst_mid_busy", 64'(busy_a), 64'd0);
      chk("rst_mid_ren", 64'(src_ren_a), 64'd0);
      for (int i = 0; i < 4; i++) begin
         fq[i].delete();
         mq[i].delete();
      end
      exp_q[0].delete();
      step(1);
      rst_n = 1'b1;
      mptr[0] = 0;
      hold_v[0] = 1'b0;
      chk_en[0] = 1'b1;
      load(0, 1, 4); load(0, 0, 4);
      model_run(0);
      step(1);
      #1;
      chk("restart_ren", 64'(src_ren_a), 64'b0001);
      wait_drain(0, 200, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

endmodule
